sap_microseq: RTL and testbench
===============================

# sap_microseq

Parametrised microcoded control sequencer for the SAP CPU family. It replaces the fixed opcode/step decoder with a ROM-driven sequencer that supports variable instruction length, conditional micro-steps on ALU flags, memory wait-states and clean instruction-boundary halting. It sits between the instruction register (opcode), the ALU flag register and all datapath control inputs.

## Interface
- OP_W, 4, opcode width
- STEP_W, 3, micro-step counter width (max 2^STEP_W steps per instruction)
- CTRL_W, 18, control-word width (bit map in package)
- FLAG_W, 2, flag width (bit 0 = Z, bit 1 = C)
- UCODE_FILE, "ucode.hex", ROM init file
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- halt  in  1  external halt request, level
- opcode  in  OP_W  current IR high nibble
- flags  in  FLAG_W  registered ALU flags
- mem_ready  in  1  RAM ready; low = wait-state
- ctrl  out  CTRL_W  registered control word to datapath
- step  out  STEP_W  current micro-step
- halted  out  1  sequencer parked
- seq_err  out  1  sticky: step counter overflowed without END

## Operation
- ROM word = {COND[1:0], WAIT, END, CTRL[CTRL_W-1:0]}, 2^(OP_W+STEP_W) entries, address {opcode, step}.
- Steps 0 and 1 of every opcode hold the fetch words (PC_OUT|MAR_IN; PC_INC|RAM_OUT|IR_IN).
- COND: 0 always, 1 Z, 2 C, 3 NZ. If condition false, CTRL issued as 0; END/WAIT still honoured.
- States: RUN, HALTED.
- RUN, per edge: fetch word w = rom[{opcode,step}].
  - w.WAIT && !mem_ready: ctrl <= gated w.CTRL, step held (re-issue).
  - else ctrl <= gated w.CTRL; step <= w.END ? 0 : step+1.
  - step == 2^STEP_W-1 without END: step <= 0, seq_err <= 1.
- Halt entry: (a) halt high when next step is 0 (instruction boundary) -> HALTED, ctrl <= 0; halt mid-instruction never truncates an instruction. (b) issued word has CTRL[HLT] set -> HALTED next edge, halt latched permanently.
- HALTED: ctrl = 0, step = 0, halted = 1. Exit to RUN when halt low, only if entry was (a); entry (b) exits only by reset.
- Reset (any state, any step): state RUN, step 0, ctrl 0, halted 0, seq_err 0, latched HLT cleared.

## Timing
- One-cycle latency: ctrl for step n valid the cycle after the edge that sampled step n.
- opcode must be stable from the edge after step 1 issues until END; IR load in step 1 guarantees this.
- flags sampled in the same cycle the conditional word is looked up.
- Wait-state: each cycle mem_ready low on a WAIT word adds exactly one cycle; ctrl stays asserted throughout.
- halt and mem_ready both active at a boundary: wait has priority; halt takes effect at the boundary after the wait completes.
- Exit from HALTED: first fetch word issued on the edge after halt samples low.

## Structure
- Package sap_pkg: control-bit index constants (HLT, PC_INC, PC_OUT, JUMP, ACC_IN, ACC_OUT, ALU_OUT, ADD_SUB, ALU_1, ALU_0, XOR_NOT, MAR_IN, RAM_IN, RAM_OUT, BR_IN, IR_IN, IR_OUT, OPR_IN), COND encodings, state enum, opcode constants.
- Sub-module sap_ucode_rom: synchronous-free combinational ROM, parameters OP_W/STEP_W/word width/UCODE_FILE.

## Test plan
- Reset, opcode 0x1 (LDA), mem_ready=1 -> ctrl sequence PC_OUT|MAR_IN, PC_INC|RAM_OUT|IR_IN, MAR_IN|IR_OUT, RAM_OUT|ACC_IN, then step 0 again (4 cycles).
- Step 1 WAIT with mem_ready low 3 cycles -> PC_INC|RAM_OUT|IR_IN held 4 cycles, step stays 1, then step 2.
- Opcode JZ, flags Z=0 -> step-2 ctrl = 0; Z=1 -> JUMP|IR_OUT.
- halt raised at step 2 of ADD (opcode 0x4) -> step 4 ALU word still issued, halted=1 next edge; halt low -> fetch resumes next edge.
- Opcode 0xF (HLT) -> halted=1, halt toggling has no effect; reset -> step 0, halted 0.
- ROM entry with no END for 8 steps -> seq_err=1, step wraps to 0; reset mid-instruction at step 3 -> ctrl 0, step 0 next cycle.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP microcoded sequencer: control-bit map, branch
// conditions, opcodes, sequencer states and the default microcode image.
package sap_pkg;

  localparam int SAP_CTRL_W = 18;
  localparam int SAP_WORD_W = SAP_CTRL_W + 4;

  localparam int HLT     = 17;
  localparam int PC_INC  = 16;
  localparam int PC_OUT  = 15;
  localparam int JUMP    = 14;
  localparam int ACC_IN  = 13;
  localparam int ACC_OUT = 12;
  localparam int ALU_OUT = 11;
  localparam int ADD_SUB = 10;
  localparam int ALU_1   = 9;
  localparam int ALU_0   = 8;
  localparam int XOR_NOT = 7;
  localparam int MAR_IN  = 6;
  localparam int RAM_IN  = 5;
  localparam int RAM_OUT = 4;
  localparam int BR_IN   = 3;
  localparam int IR_IN   = 2;
  localparam int IR_OUT  = 1;
  localparam int OPR_IN  = 0;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_Z      = 2'd1;
  localparam logic [1:0] COND_C      = 2'd2;
  localparam logic [1:0] COND_NZ     = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JNZ = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_AND = 4'hB;
  localparam logic [3:0] OP_OR  = 4'hC;
  localparam logic [3:0] OP_XOR = 4'hD;
  localparam logic [3:0] OP_BAD = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HALTED  = 1'b1
  } seq_state_t;

  function automatic logic [SAP_CTRL_W-1:0] cbit(input int idx);
    return SAP_CTRL_W'(1) << idx;
  endfunction

  // Word layout {COND, WAIT, END, CTRL}; slots past an instruction's END terminate cleanly.
  function automatic logic [SAP_WORD_W-1:0] ucode_word(input int op, input int stp);
    logic [SAP_CTRL_W-1:0] c;
    logic [1:0]            cnd;
    logic                  wt;
    logic                  en;
    logic [3:0]            o;
    c   = '0;
    cnd = COND_ALWAYS;
    wt  = 1'b0;
    en  = 1'b0;
    o   = 4'(op);
    if (stp == 0) begin
      c = cbit(PC_OUT) | cbit(MAR_IN);
    end else if (stp == 1) begin
      c  = cbit(PC_INC) | cbit(RAM_OUT) | cbit(IR_IN);
      wt = 1'b1;
    end else begin
      en = 1'b1;
      case (o)
        OP_LDA, OP_STA: begin
          if (stp == 2) begin
            c  = cbit(MAR_IN) | cbit(IR_OUT);
            en = 1'b0;
          end else if (stp == 3) begin
            c = (o == OP_LDA) ? (cbit(RAM_OUT) | cbit(ACC_IN)) : (cbit(ACC_OUT) | cbit(RAM_IN));
          end
        end
        OP_LDI: if (stp == 2) c = cbit(IR_OUT) | cbit(ACC_IN);
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          if (stp == 2) begin
            c  = cbit(MAR_IN) | cbit(IR_OUT);
            en = 1'b0;
          end else if (stp == 3) begin
            c  = cbit(RAM_OUT) | cbit(BR_IN);
            en = 1'b0;
          end else if (stp == 4) begin
            c = cbit(ALU_OUT) | cbit(ACC_IN);
            if (o == OP_SUB) c = c | cbit(ADD_SUB);
            if (o == OP_AND) c = c | cbit(ALU_0);
            if (o == OP_OR)  c = c | cbit(ALU_1);
            if (o == OP_XOR) c = c | cbit(XOR_NOT);
          end
        end
        OP_JMP, OP_JZ, OP_JC, OP_JNZ: begin
          if (stp == 2) begin
            c = cbit(JUMP) | cbit(IR_OUT);
            if (o == OP_JZ)  cnd = COND_Z;
            if (o == OP_JC)  cnd = COND_C;
            if (o == OP_JNZ) cnd = COND_NZ;
          end
        end
        OP_OUT: if (stp == 2) c = cbit(ACC_OUT) | cbit(OPR_IN);
        OP_HLT: if (stp == 2) c = cbit(HLT);
        OP_BAD: en = 1'b0;
        default: ;
      endcase
    end
    return {cnd, wt, en, c};
  endfunction

endpackage

// File: rtl/sap_ucode_rom.sv
// Combinational microcode ROM addressed by {opcode, step}; an empty image name
// yields a blank ROM.
module sap_ucode_rom
  import sap_pkg::*;
#(
  parameter int    OP_W       = 4,
  parameter int    STEP_W     = 3,
  parameter int    WORD_W     = SAP_WORD_W,
  parameter string UCODE_FILE = "ucode.hex"
) (
  input  logic [OP_W+STEP_W-1:0] addr,
  output logic [WORD_W-1:0]      word
);

  localparam bit IMAGE_PRESENT = (UCODE_FILE != "");

  always_comb begin
    word = '0;
    if (IMAGE_PRESENT)
      word = WORD_W'(ucode_word(int'(addr[OP_W+STEP_W-1:STEP_W]), int'(addr[STEP_W-1:0])));
  end

endmodule

// File: rtl/sap_microseq.sv
// ROM-driven control sequencer for the SAP CPU: conditional micro-steps,
// memory wait-states and instruction-boundary halting.
module sap_microseq
  import sap_pkg::*;
#(
  parameter int    OP_W       = 4,
  parameter int    STEP_W     = 3,
  parameter int    CTRL_W     = 18,
  parameter int    FLAG_W     = 2,
  parameter string UCODE_FILE = "ucode.hex"
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FLAG_W-1:0] flags,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted,
  output logic              seq_err
);

  localparam int WORD_W = CTRL_W + 4;

  logic [WORD_W-1:0] word;
  logic [1:0]        w_cond;
  logic              w_wait;
  logic              w_end;
  logic [CTRL_W-1:0] w_ctrl;
  logic [CTRL_W-1:0] gated;
  logic              cond_ok;
  logic              stall;
  logic              boundary_halt;
  seq_state_t        state;
  logic              hlt_latched;

  sap_ucode_rom #(
    .OP_W       (OP_W),
    .STEP_W     (STEP_W),
    .WORD_W     (WORD_W),
    .UCODE_FILE (UCODE_FILE)
  ) u_rom (
    .addr (/*{opcode, step}*/ {opcode, step}),
    .word (word)
  );

  assign w_cond = word[WORD_W-1 -: 2];
  assign w_wait = word[CTRL_W+1];
  assign w_end  = word[CTRL_W];
  assign w_ctrl = word[CTRL_W-1:0];

  always_comb begin
    case (w_cond)
      COND_Z:  cond_ok = flags[FLAG_Z];
      COND_C:  cond_ok = flags[FLAG_C];
      COND_NZ: cond_ok = !flags[FLAG_Z];
      default: cond_ok = 1'b1;
    endcase
  end

  // A failed condition suppresses the controls only; END/WAIT still steer the step counter.
  assign gated         = cond_ok ? w_ctrl : '0;
  assign stall         = w_wait && !mem_ready;
  assign boundary_halt = halt && (step == '0) && !stall;

  // Issue stage: the looked-up word lands in ctrl one edge after its step is sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      step        <= '0;
      ctrl        <= '0;
      halted      <= 1'b0;
      seq_err     <= 1'b0;
      hlt_latched <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hlt_latched || boundary_halt) begin
            state  <= ST_HALTED;
            ctrl   <= '0;
            step   <= '0;
            halted <= 1'b1;
          end else begin
            ctrl <= gated;
            if (gated[HLT]) hlt_latched <= 1'b1;
            if (!stall) begin
              if (w_end) begin
                step <= '0;
              end else if (step == '1) begin
                step    <= '0;
                seq_err <= 1'b1;
              end else begin
                step <= step + STEP_W'(1);
              end
            end
          end
        end
        default: begin
          ctrl <= '0;
          step <= '0;
          // A HLT instruction parks the sequencer until reset.
          if (!halt && !hlt_latched) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_microseq.sv
// Bench for sap_microseq: directed instruction walkthroughs, then randomized
// traffic against an instruction-level reference model.
module tb_sap_microseq;
  import sap_pkg::*;

  localparam int OP_W   = 4;
  localparam int STEP_W = 3;
  localparam int CTRL_W = 18;
  localparam int FLAG_W = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              halt = 1'b0;
  logic              mem_ready = 1'b1;
  logic [OP_W-1:0]   opcode = '0;
  logic [FLAG_W-1:0] flags = '0;
  logic [CTRL_W-1:0] ctrl;
  logic [STEP_W-1:0] step;
  logic              halted;
  logic              seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  sap_microseq #(
    .OP_W(OP_W), .STEP_W(STEP_W), .CTRL_W(CTRL_W), .FLAG_W(FLAG_W), .UCODE_FILE("ucode.hex")
  ) dut (
    .clock(clock), .reset(reset), .halt(halt), .opcode(opcode), .flags(flags),
    .mem_ready(mem_ready), .ctrl(ctrl), .step(step), .halted(halted), .seq_err(seq_err)
  );

  always #5 clock = ~clock;

  // Instruction descriptions: length in steps (0 = never ends), branch condition, steps 2..4.
  logic [CTRL_W-1:0] body [16][8];
  int                len  [16];
  int                jcond[16];
  logic [CTRL_W-1:0] w_fetch0, w_fetch1;

  // Reference model state
  bit                m_run;
  int                m_step;
  logic [CTRL_W-1:0] m_ctrl;
  bit                m_halted, m_err, m_hlt;

  function automatic logic [CTRL_W-1:0] bm(input int i);
    return CTRL_W'(1) << i;
  endfunction

  task automatic def(input logic [3:0] op, input int l, input int cnd,
                     input logic [CTRL_W-1:0] s2, input logic [CTRL_W-1:0] s3,
                     input logic [CTRL_W-1:0] s4);
    for (int s = 0; s < 8; s++) body[op][s] = '0;
    body[op][2] = s2;
    body[op][3] = s3;
    body[op][4] = s4;
    len[op]     = l;
    jcond[op]   = cnd;
  endtask

  function automatic bit taken(input int op);
    case (jcond[op])
      1:       return flags[0] == 1'b1;
      2:       return flags[1] == 1'b1;
      3:       return flags[0] == 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [CTRL_W-1:0] step_ctrl(input int op, input int s);
    if (s == 0) return w_fetch0;
    if (s == 1) return w_fetch1;
    if (s > 4) return '0;
    if (s == 2 && !taken(op)) return '0;
    return body[op][s];
  endfunction

  task automatic model_edge();
    int  op;
    bit  waiting;
    op      = int'(opcode);
    waiting = (m_step == 1) && !mem_ready;
    if (reset) begin
      m_run = 1; m_step = 0; m_ctrl = '0; m_halted = 0; m_err = 0; m_hlt = 0;
    end else if (!m_run) begin
      m_ctrl = '0;
      m_step = 0;
      if (!halt && !m_hlt) begin
        m_run    = 1;
        m_halted = 0;
      end
    end else if (m_hlt || (halt && m_step == 0 && !waiting)) begin
      m_run = 0; m_halted = 1; m_ctrl = '0; m_step = 0;
    end else begin
      m_ctrl = step_ctrl(op, m_step);
      if (m_ctrl[HLT]) m_hlt = 1;
      if (!waiting) begin
        if (len[op] != 0 && m_step == len[op] - 1) begin
          m_step = 0;
        end else if (m_step == 7) begin
          m_step = 0;
          m_err  = 1;
        end else begin
          m_step++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [CTRL_W-1:0] c, input int s,
                            input logic h);
    check({tag, " ctrl"}, 32'(ctrl), 32'(c));
    check({tag, " step"}, 32'(step), 32'(s));
    check({tag, " halted"}, 32'(halted), 32'(h));
  endtask

  initial begin
    logic [CTRL_W-1:0] mar_ir, alu_base;
    w_fetch0 = bm(PC_OUT) | bm(MAR_IN);
    w_fetch1 = bm(PC_INC) | bm(RAM_OUT) | bm(IR_IN);
    mar_ir   = bm(MAR_IN) | bm(IR_OUT);
    alu_base = bm(ALU_OUT) | bm(ACC_IN);
    def(OP_NOP, 3, 0, '0, '0, '0);
    def(OP_LDA, 4, 0, mar_ir, bm(RAM_OUT) | bm(ACC_IN), '0);
    def(OP_STA, 4, 0, mar_ir, bm(ACC_OUT) | bm(RAM_IN), '0);
    def(OP_LDI, 3, 0, bm(IR_OUT) | bm(ACC_IN), '0, '0);
    def(OP_ADD, 5, 0, mar_ir, bm(RAM_OUT) | bm(BR_IN), alu_base);
    def(OP_SUB, 5, 0, mar_ir, bm(RAM_OUT) | bm(BR_IN), alu_base | bm(ADD_SUB));
    def(OP_JMP, 3, 0, bm(JUMP) | bm(IR_OUT), '0, '0);
    def(OP_JZ,  3, 1, bm(JUMP) | bm(IR_OUT), '0, '0);
    def(OP_JC,  3, 2, bm(JUMP) | bm(IR_OUT), '0, '0);
    def(OP_JNZ, 3, 3, bm(JUMP) | bm(IR_OUT), '0, '0);
    def(OP_OUT, 3, 0, bm(ACC_OUT) | bm(OPR_IN), '0, '0);
    def(OP_AND, 5, 0, mar_ir, bm(RAM_OUT) | bm(BR_IN), alu_base | bm(ALU_0));
    def(OP_OR,  5, 0, mar_ir, bm(RAM_OUT) | bm(BR_IN), alu_base | bm(ALU_1));
    def(OP_XOR, 5, 0, mar_ir, bm(RAM_OUT) | bm(BR_IN), alu_base | bm(XOR_NOT));
    def(OP_BAD, 0, 0, '0, '0, '0);
    def(OP_HLT, 3, 0, bm(HLT), '0, '0);

    // Reset state
    opcode = OP_LDA;
    tick();
    tick();
    expect_out("reset", '0, 0, 1'b0);
    check("reset seq_err", 32'(seq_err), 32'(0));
    reset = 1'b0;

    // LDA with no wait-states
    tick(); expect_out("lda s0", w_fetch0, 1, 1'b0);
    tick(); expect_out("lda s1", w_fetch1, 2, 1'b0);
    tick(); expect_out("lda s2", mar_ir, 3, 1'b0);
    tick(); expect_out("lda s3", bm(RAM_OUT) | bm(ACC_IN), 0, 1'b0);
    tick(); expect_out("lda2 s0", w_fetch0, 1, 1'b0);

    // Three wait-state cycles on the IR-load step
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("wait hold", w_fetch1, 1, 1'b0);
    end
    mem_ready = 1'b1;
    tick(); expect_out("wait done", w_fetch1, 2, 1'b0);
    tick(); expect_out("lda2 s2", mar_ir, 3, 1'b0);
    tick(); expect_out("lda2 s3", bm(RAM_OUT) | bm(ACC_IN), 0, 1'b0);

    // JZ not taken, then taken
    opcode = OP_JZ;
    flags  = 2'b00;
    tick(); tick();
    tick(); expect_out("jz nz", '0, 0, 1'b0);
    flags = 2'b01;
    tick(); tick();
    tick(); expect_out("jz z", bm(JUMP) | bm(IR_OUT), 0, 1'b0);

    // Halt raised mid-ADD waits for the instruction boundary
    opcode = OP_ADD;
    tick(); tick();
    halt = 1'b1;
    tick(); expect_out("add s2", mar_ir, 3, 1'b0);
    tick(); expect_out("add s3", bm(RAM_OUT) | bm(BR_IN), 4, 1'b0);
    tick(); expect_out("add s4", alu_base, 0, 1'b0);
    tick(); expect_out("halt enter", '0, 0, 1'b1);
    tick(); expect_out("halt hold", '0, 0, 1'b1);
    halt = 1'b0;
    tick(); expect_out("halt exit", '0, 0, 1'b0);
    tick(); expect_out("resume s0", w_fetch0, 1, 1'b0);
    tick(); tick(); tick();
    tick(); expect_out("resume end", alu_base, 0, 1'b0);

    // HLT instruction parks until reset
    opcode = OP_HLT;
    tick(); tick();
    tick(); expect_out("hlt issue", bm(HLT), 0, 1'b0);
    tick(); expect_out("hlt parked", '0, 0, 1'b1);
    halt = 1'b1;
    tick(); expect_out("hlt halt hi", '0, 0, 1'b1);
    halt = 1'b0;
    tick(); expect_out("hlt halt lo", '0, 0, 1'b1);
    reset = 1'b1;
    tick(); expect_out("hlt reset", '0, 0, 1'b0);
    reset = 1'b0;

    // Missing END: counter wraps and flags the error
    opcode = OP_BAD;
    tick(); tick();
    for (int s = 3; s <= 7; s++) begin
      tick(); expect_out("bad walk", '0, s, 1'b0);
    end
    check("bad pre err", 32'(seq_err), 32'(0));
    tick(); expect_out("bad wrap", '0, 0, 1'b0);
    check("bad err", 32'(seq_err), 32'(1));
    tick(); check("bad err sticky", 32'(seq_err), 32'(1));

    // Reset in the middle of an instruction
    opcode = OP_ADD;
    tick(); tick(); expect_out("mid s2", mar_ir, 3, 1'b0);
    reset = 1'b1;
    tick(); expect_out("mid reset", '0, 0, 1'b0);
    check("mid reset err", 32'(seq_err), 32'(0));
    reset = 1'b0;

    // Randomized traffic against the reference model
    reset = 1'b1;
    halt  = 1'b0;
    model_edge();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (m_step <= 1 && $urandom_range(0, 2) == 0) opcode = OP_W'($urandom_range(0, 13));
      flags     = FLAG_W'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      reset = ($urandom_range(0, 199) == 0);
      model_edge();
      tick();
      check("rnd ctrl", 32'(ctrl), 32'(m_ctrl));
      check("rnd step", 32'(step), 32'(m_step));
      check("rnd halted", 32'(halted), 32'(m_halted));
      check("rnd seq_err", 32'(seq_err), 32'(m_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
